wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage of the Y86-64 pipeline: W pipeline register fed by the memory stage,
//  15x64-bit register file with dual async read ports for decode, retire counter and
//  sticky halt on non-AOK status. Sits directly downstream of memory, feeds decode/forwarding.
// PARAMETERS
//  NREGS   15   architectural registers; index 4'hF = RNONE, never written
//  WIDTH   64   data width
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous active-high reset
//  m_stat    in   3      status from memory stage: 1=AOK 2=HLT 3=ADR 4=INS
//  micode    in   4      icode from memory stage
//  mcnd      in   1      condition flag from memory stage
//  mdstE     in   4      dstE from memory stage
//  mdstM     in   4      dstM from memory stage
//  mvalE     in   64     valE from memory stage
//  mvalM     in   64     valM from memory stage
//  W_stall   in   1      hold W register
//  W_bubble  in   1      load nop bubble into W
//  srcA      in   4      decode read port A index
//  srcB      in   4      decode read port B index
//  rvalA     out  64     register read A (0 when srcA==F)
//  rvalB     out  64     register read B (0 when srcB==F)
//  Wstat Wicode Wcnd WdstE WdstM WvalE WvalM  out  3/4/1/4/4/64/64  W register contents
//  halted    out  1      sticky: a non-AOK instruction has retired
//  retired   out  64     count of retired AOK non-bubble instructions
// BEHAVIOUR
//  - Clock/reset: single clk; rst synchronous, active-high, overrides stall/bubble.
//  - Reset values: Wstat=1, Wicode=1 (nop), Wcnd=0, WdstE=WdstM=F, WvalE=WvalM=0,
//    all regs=0, halted=0, retired=0.
//  - Edge priority per posedge: rst > W_stall > W_bubble > load from m*.
//  - Load: W <= {m_stat,micode,mcnd,mdstE,mdstM,mvalE,mvalM}. Bubble: W <= reset values.
//  - Stall: W holds; NO register write, NO counter change on that edge.
//  - Retire edge = any posedge with !rst && !W_stall && !halted: current W contents
//    commit, simultaneously with W being replaced.
//    * Wstat==AOK: if WdstE!=F and !(Wicode==2 && !Wcnd) write regs[WdstE]<=WvalE;
//      if WdstM!=F write regs[WdstM]<=WvalM; WdstE==WdstM!=F -> WvalM wins.
//      retired += 1 unless W is a bubble (Wicode==1 && WdstE==F && WdstM==F).
//    * Wstat!=AOK: no write, no count; halted<=1 (sticky until rst).
//  - halted=1: all writes/counting suppressed; W still loads/bubbles normally.
//  - Read ports combinational from regs; index F returns 0. retired wraps 2^64-1 -> 0.
//  - Latency: m* -> W: 1 cycle; W -> register file visible: next edge.
// CONFIGURATION
//  WB_BYPASS_EN defined: rvalA/rvalB forward the pending commit (WvalM for matching WdstM,
//    else WvalE for matching enabled WdstE) when retire conditions hold, removing the
//    same-cycle read hazard. Undefined: reads return stored regs only; decode forwarding
//    must cover the W stage.
// TESTING
//  1. rst high 2 cycles -> Wicode=1, WdstE=F, halted=0, retired=0, rvalA(srcA=0)=0.
//  2. load irmovq: m_stat=1,micode=3,mdstE=2,mvalE=42; 2 edges -> rvalB(srcB=2)=42, retired=1.
//  3. mrmovq+popq same dst: WdstE=WdstM=4, WvalE=8, WvalM=99 -> regs[4]=99.
//  4. cmov not taken: Wicode=2,Wcnd=0,WdstE=3,WvalE=7 -> regs[3] unchanged, retired+1.
//  5. W_stall=1 for 3 edges with irmovq in W -> no write until release; retired +1 exactly once.
//  6. m_stat=2 (HLT) then irmovq to r1 -> halted=1, regs[1] unchanged, retired frozen;
//     rst -> halted=0. With WB_BYPASS_EN: srcA==WdstE in retire cycle -> rvalA=WvalE.

Source files
------------

// File: rtl/wb_if.sv
// Bundle between the memory stage, decode and the write-back stage.
// Memory-stage fields, stall/bubble controls, read ports and W register contents.
interface wb_if #(
  parameter int unsigned WIDTH = 64
);
  logic [2:0]       m_stat;
  logic [3:0]       micode;
  logic             mcnd;
  logic [3:0]       mdstE;
  logic [3:0]       mdstM;
  logic [WIDTH-1:0] mvalE;
  logic [WIDTH-1:0] mvalM;
  logic             W_stall;
  logic             W_bubble;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [WIDTH-1:0] rvalA;
  logic [WIDTH-1:0] rvalB;
  logic [2:0]       Wstat;
  logic [3:0]       Wicode;
  logic             Wcnd;
  logic [3:0]       WdstE;
  logic [3:0]       WdstM;
  logic [WIDTH-1:0] WvalE;
  logic [WIDTH-1:0] WvalM;
  logic             halted;
  logic [WIDTH-1:0] retired;

  modport master (
    output m_stat, micode, mcnd, mdstE, mdstM, mvalE, mvalM, W_stall, W_bubble, srcA, srcB,
    input  rvalA, rvalB, Wstat, Wicode, Wcnd, WdstE, WdstM, WvalE, WvalM, halted, retired
  );

  modport slave (
    input  m_stat, micode, mcnd, mdstE, mdstM, mvalE, mvalM, W_stall, W_bubble, srcA, srcB,
    output rvalA, rvalB, Wstat, Wicode, Wcnd, WdstE, WdstM, WvalE, WvalM, halted, retired
  );
endinterface

// File: rtl/wb_stage.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file, retire counter, halt.
// Optional macro WB_BYPASS_EN forwards the pending commit onto the read ports.
module wb_stage #(
  parameter int unsigned NREGS = 15,
  parameter int unsigned WIDTH = 64
) (
  input logic clk,
  input logic rst,
  wb_if.slave bus
);
  localparam logic [3:0] RNone     = 4'hF;
  localparam logic [2:0] StatAok   = 3'd1;
  localparam logic [3:0] IcodeNop  = 4'd1;
  localparam logic [3:0] IcodeCmov = 4'd2;

  typedef struct packed {
    logic [2:0]       stat;
    logic [3:0]       icode;
    logic             cnd;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
    logic [WIDTH-1:0] val_e;
    logic [WIDTH-1:0] val_m;
  } w_t;

  w_t               w_q, w_d, w_reset;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] retired_q, retired_d;
  logic             retire, commit, we_e, we_m, is_bubble;

  always_comb begin
    w_reset = '{stat: StatAok, icode: IcodeNop, cnd: 1'b0, dst_e: RNone, dst_m: RNone,
                val_e: '0, val_m: '0};
    // A commit happens on every non-stalled edge until a non-AOK status retires.
    retire    = !rst && !bus.W_stall && !halted_q;
    commit    = retire && (w_q.stat == StatAok);
    we_e      = commit && (w_q.dst_e != RNone) && !((w_q.icode == IcodeCmov) && !w_q.cnd);
    we_m      = commit && (w_q.dst_m != RNone);
    is_bubble = (w_q.icode == IcodeNop) && (w_q.dst_e == RNone) && (w_q.dst_m == RNone);

    regs_d = regs_q;
    if (we_e) regs_d[w_q.dst_e] = w_q.val_e;
    if (we_m) regs_d[w_q.dst_m] = w_q.val_m;

    retired_d = retired_q + WIDTH'(commit && !is_bubble);
    halted_d  = halted_q | (retire && (w_q.stat != StatAok));

    if (bus.W_stall) begin
      w_d = w_q;
    end else if (bus.W_bubble) begin
      w_d = w_reset;
    end else begin
      w_d = '{stat: bus.m_stat, icode: bus.micode, cnd: bus.mcnd, dst_e: bus.mdstE,
              dst_m: bus.mdstM, val_e: bus.mvalE, val_m: bus.mvalM};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= w_reset;
      halted_q  <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      w_q       <= w_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [3:0] src);
    logic [WIDTH-1:0] val;
    val = (src == RNone) ? '0 : regs_q[src];
`ifdef WB_BYPASS_EN
    // WvalM takes precedence, matching the write order of the commit itself.
    if (we_m && (w_q.dst_m == src)) begin
      val = w_q.val_m;
    end else if (we_e && (w_q.dst_e == src)) begin
      val = w_q.val_e;
    end
`endif
    return val;
  endfunction

  always_comb begin
    bus.rvalA = read_port(bus.srcA);
    bus.rvalB = read_port(bus.srcB);
  end

  assign bus.Wstat   = w_q.stat;
  assign bus.Wicode  = w_q.icode;
  assign bus.Wcnd    = w_q.cnd;
  assign bus.WdstE   = w_q.dst_e;
  assign bus.WdstM   = w_q.dst_m;
  assign bus.WvalE   = w_q.val_e;
  assign bus.WvalM   = w_q.val_m;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_if #(.WIDTH(64)) bus ();
  wb_stage #(.NREGS(15), .WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [2:0]  mw_stat;
  logic [3:0]  mw_icode, mw_dste, mw_dstm;
  logic        mw_cnd;
  logic [63:0] mw_vale, mw_valm;
  logic [63:0] mregs [15];
  logic        m_halted;
  logic [63:0] m_retired;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      {mw_stat, mw_icode, mw_cnd, mw_dste, mw_dstm, mw_vale, mw_valm} =
        {3'd1, 4'd1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0};
      foreach (mregs[i]) mregs[i] = 64'd0;
      m_halted    = 1'b0;
      m_retired   = 64'd0;
      model_valid = 1'b1;
    end else if (!bus.W_stall) begin
      if (!m_halted) begin
        if (mw_stat == 3'd1) begin
          if (mw_dste != 4'hF && !(mw_icode == 4'd2 && !mw_cnd)) mregs[mw_dste] = mw_vale;
          if (mw_dstm != 4'hF) mregs[mw_dstm] = mw_valm;
          if (!(mw_icode == 4'd1 && mw_dste == 4'hF && mw_dstm == 4'hF)) m_retired++;
        end else begin
          m_halted = 1'b1;
        end
      end
      if (bus.W_bubble)
        {mw_stat, mw_icode, mw_cnd, mw_dste, mw_dstm, mw_vale, mw_valm} =
          {3'd1, 4'd1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0};
      else
        {mw_stat, mw_icode, mw_cnd, mw_dste, mw_dstm, mw_vale, mw_valm} =
          {bus.m_stat, bus.micode, bus.mcnd, bus.mdstE, bus.mdstM, bus.mvalE, bus.mvalM};
    end
  end

  function automatic logic [63:0] model_read(input logic [3:0] src);
    if (src == 4'hF) return 64'd0;
`ifdef WB_BYPASS_EN
    if (!rst && !bus.W_stall && !m_halted && mw_stat == 3'd1) begin
      if (mw_dstm == src) return mw_valm;
      if (mw_dste == src && !(mw_icode == 4'd2 && !mw_cnd)) return mw_vale;
    end
`endif
    return mregs[src];
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      chk("Wstat", 64'(bus.Wstat), 64'(mw_stat));
      chk("Wicode", 64'(bus.Wicode), 64'(mw_icode));
      chk("Wcnd", 64'(bus.Wcnd), 64'(mw_cnd));
      chk("WdstE", 64'(bus.WdstE), 64'(mw_dste));
      chk("WdstM", 64'(bus.WdstM), 64'(mw_dstm));
      chk("WvalE", bus.WvalE, mw_vale);
      chk("WvalM", bus.WvalM, mw_valm);
      chk("halted", 64'(bus.halted), 64'(m_halted));
      chk("retired", bus.retired, m_retired);
      chk("rvalA", bus.rvalA, model_read(bus.srcA));
      chk("rvalB", bus.rvalB, model_read(bus.srcB));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic cn,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    bus.m_stat = st; bus.micode = ic; bus.mcnd = cn;
    bus.mdstE = de; bus.mdstM = dm; bus.mvalE = ve; bus.mvalM = vm;
  endtask

  task automatic set_nop();
    set_m(3'd1, 4'd1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
  endtask

  initial begin
    set_nop();
    bus.W_stall = 1'b0; bus.W_bubble = 1'b0; bus.srcA = 4'd0; bus.srcB = 4'd0;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_Wicode", 64'(bus.Wicode), 64'd1);
    chk("rst_WdstE", 64'(bus.WdstE), 64'hF);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_retired", bus.retired, 64'd0);
    chk("rst_rvalA", bus.rvalA, 64'd0);

    // irmovq $42, r2
    set_m(3'd1, 4'd3, 1'b0, 4'd2, 4'hF, 64'd42, 64'd0);
    bus.srcB = 4'd2;
    tick();
    set_nop();
    tick();
    chk("irmovq_rvalB", bus.rvalB, 64'd42);
    chk("irmovq_retired", bus.retired, 64'd1);

    // Same destination on both ports: M value wins
    set_m(3'd1, 4'd5, 1'b0, 4'd4, 4'd4, 64'd8, 64'd99);
    tick();
    set_nop();
    tick();
    bus.srcA = 4'd4;
    #1;
    chk("dual_dst_rvalA", bus.rvalA, 64'd99);
    chk("dual_dst_retired", bus.retired, 64'd2);

    // cmov not taken
    set_m(3'd1, 4'd2, 1'b0, 4'd3, 4'hF, 64'd7, 64'd0);
    tick();
    set_nop();
    tick();
    bus.srcA = 4'd3;
    #1;
    chk("cmov_nt_rvalA", bus.rvalA, 64'd0);
    chk("cmov_nt_retired", bus.retired, 64'd3);

    // Stall for 3 edges with irmovq in W
    set_m(3'd1, 4'd3, 1'b0, 4'd5, 4'hF, 64'd55, 64'd0);
    tick();
    set_nop();
    bus.W_stall = 1'b1;
    bus.srcA = 4'd5;
    tick(); tick(); tick();
    chk("stall_rvalA", bus.rvalA, 64'd0);
    chk("stall_retired", bus.retired, 64'd3);
    chk("stall_WvalE", bus.WvalE, 64'd55);
    bus.W_stall = 1'b0;
    tick();
    chk("release_rvalA", bus.rvalA, 64'd55);
    chk("release_retired", bus.retired, 64'd4);

    // HLT then irmovq to r1
    set_m(3'd2, 4'd0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
    tick();
    set_m(3'd1, 4'd3, 1'b0, 4'd1, 4'hF, 64'd11, 64'd0);
    tick();
    chk("hlt_halted", 64'(bus.halted), 64'd1);
    set_nop();
    tick(); tick();
    bus.srcA = 4'd1;
    #1;
    chk("hlt_rvalA", bus.rvalA, 64'd0);
    chk("hlt_retired", bus.retired, 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_halted", 64'(bus.halted), 64'd0);
    chk("rst2_retired", bus.retired, 64'd0);

    // Read in the retire cycle of a write to the same register
    set_m(3'd1, 4'd3, 1'b0, 4'd6, 4'hF, 64'd77, 64'd0);
    tick();
    set_nop();
    bus.srcA = 4'd6;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_rvalA", bus.rvalA, 64'd77);
`else
    chk("nobypass_rvalA", bus.rvalA, 64'd0);
`endif
    tick();
    chk("committed_rvalA", bus.rvalA, 64'd77);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) == 0);
      bus.W_stall  = ($urandom_range(4) == 0);
      bus.W_bubble = ($urandom_range(7) == 0);
      bus.m_stat   = ($urandom_range(39) == 0) ? 3'($urandom_range(4, 2)) : 3'd1;
      bus.micode   = 4'($urandom_range(11));
      bus.mcnd     = 1'($urandom_range(1));
      bus.mdstE    = ($urandom_range(2) == 0) ? 4'hF : 4'($urandom_range(15));
      bus.mdstM    = ($urandom_range(2) == 0) ? 4'hF : 4'($urandom_range(15));
      bus.mvalE    = {$urandom, $urandom};
      bus.mvalM    = {$urandom, $urandom};
      bus.srcA     = 4'($urandom_range(15));
      bus.srcB     = 4'($urandom_range(15));
      tick();
    end

    rst = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
